crop_word_packer: RTL

Downstream stage of the crop-inference block: accepts the serialized 8-bit post-crop pixel stream with its crop index and packs it into 256-bit words for the host DMA path. Each crop starts on a fresh word, and a partial final word is zero-padded and flagged via `m_axis_tkeep`. `m_axis_tlast` marks the last word of a frame, i.e. after all crops. The block also checks the incoming crop index against its own crop sequence.

---
 rtl/crop_word_packer.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/crop_word_packer.sv
// Packs the serialized post-crop Mono8 stream into 256-bit words. Every crop starts
// on a fresh word, and a one-word pending register absorbs a completion while the output stalls.
module crop_word_packer #(
  parameter int OUT_ROWS       = 20,
  parameter int OUT_COLS       = 20,
  parameter int NUM_CROPS      = 3,
  parameter int BYTES_PER_WORD = 32,
  localparam int CW  = (NUM_CROPS > 1) ? $clog2(NUM_CROPS) : 1,
  localparam int PIX = OUT_ROWS * OUT_COLS,
  localparam int PW  = (PIX > 1) ? $clog2(PIX) : 1,
  localparam int BW  = $clog2(BYTES_PER_WORD),
  localparam int DW  = 8 * BYTES_PER_WORD
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      s_axis_tvalid,
  output logic                      s_axis_tready,
  input  logic [7:0]                s_axis_tdata,
  input  logic [CW-1:0]             s_crop_idx,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic [DW-1:0]             m_axis_tdata,
  output logic [BYTES_PER_WORD-1:0] m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic [CW-1:0]             m_axis_tuser,
  output logic                      crop_err,
  output logic                      frame_done
);

  typedef enum logic {S_FILL = 1'b0, S_PEND = 1'b1} state_t;

  state_t                    state_q;
  logic [BW-1:0]             byte_cnt_q, byte_cnt_d;
  logic [PW-1:0]             pix_cnt_q, pix_cnt_d;
  logic [CW-1:0]             crop_cnt_q, crop_cnt_d;
  logic [DW-1:0]             asm_q, asm_d;
  logic                      crop_err_q, crop_err_d;
  logic                      frame_done_q;

  logic                      ovalid_q, olast_q;
  logic [DW-1:0]             odata_q;
  logic [BYTES_PER_WORD-1:0] okeep_q;
  logic [CW-1:0]             ouser_q;

  logic                      plast_q;
  logic [DW-1:0]             pdata_q;
  logic [BYTES_PER_WORD-1:0] pkeep_q;
  logic [CW-1:0]             puser_q;

  logic                      accept, end_crop, last_crop, word_done, out_hs;
  logic [DW-1:0]             word_data;
  logic [BYTES_PER_WORD-1:0] word_keep;
  logic                      word_last;

  assign s_axis_tready = (state_q == S_FILL);
  assign accept        = s_axis_tvalid && s_axis_tready;
  assign end_crop      = (pix_cnt_q == PW'(PIX - 1));
  assign last_crop     = (crop_cnt_q == CW'(NUM_CROPS - 1));
  assign word_done     = accept && ((byte_cnt_q == BW'(BYTES_PER_WORD - 1)) || end_crop);
  assign out_hs        = ovalid_q && m_axis_tready;

  // Completed word = assembly with the current pixel merged in; unwritten bytes are already zero.
  always_comb begin
    word_data = asm_q;
    word_data[8*byte_cnt_q +: 8] = s_axis_tdata;
    word_keep = {BYTES_PER_WORD{1'b1}} >> (BW'(BYTES_PER_WORD - 1) - byte_cnt_q);
    word_last = end_crop && last_crop;
  end

  always_comb begin
    byte_cnt_d = byte_cnt_q;
    pix_cnt_d  = pix_cnt_q;
    crop_cnt_d = crop_cnt_q;
    asm_d      = asm_q;
    crop_err_d = crop_err_q;
    if (accept) begin
      if (s_crop_idx != crop_cnt_q) crop_err_d = 1'b1;
      if (word_done) begin
        byte_cnt_d = '0;
        asm_d      = '0;
      end else begin
        byte_cnt_d = byte_cnt_q + 1'b1;
        asm_d      = word_data;
      end
      if (end_crop) begin
        pix_cnt_d  = '0;
        crop_cnt_d = last_crop ? '0 : crop_cnt_q + 1'b1;
      end else begin
        pix_cnt_d = pix_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_FILL;
      byte_cnt_q   <= '0;
      pix_cnt_q    <= '0;
      crop_cnt_q   <= '0;
      asm_q        <= '0;
      crop_err_q   <= 1'b0;
      frame_done_q <= 1'b0;
      ovalid_q     <= 1'b0;
      odata_q      <= '0;
      okeep_q      <= '0;
      olast_q      <= 1'b0;
      ouser_q      <= '0;
      pdata_q      <= '0;
      pkeep_q      <= '0;
      plast_q      <= 1'b0;
      puser_q      <= '0;
    end else begin
      byte_cnt_q   <= byte_cnt_d;
      pix_cnt_q    <= pix_cnt_d;
      crop_cnt_q   <= crop_cnt_d;
      asm_q        <= asm_d;
      crop_err_q   <= crop_err_d;
      frame_done_q <= out_hs && olast_q;
      case (state_q)
        S_FILL: begin
          if (word_done && (!ovalid_q || m_axis_tready)) begin
            ovalid_q <= 1'b1;
            odata_q  <= word_data;
            okeep_q  <= word_keep;
            olast_q  <= word_last;
            ouser_q  <= crop_cnt_q;
          end else if (word_done) begin
            pdata_q <= word_data;
            pkeep_q <= word_keep;
            plast_q <= word_last;
            puser_q <= crop_cnt_q;
            state_q <= S_PEND;
          end else if (out_hs) begin
            ovalid_q <= 1'b0;
          end
        end
        S_PEND: begin
          // Output is necessarily full here; the held word replaces it on acceptance.
          if (m_axis_tready) begin
            ovalid_q <= 1'b1;
            odata_q  <= pdata_q;
            okeep_q  <= pkeep_q;
            olast_q  <= plast_q;
            ouser_q  <= puser_q;
            state_q  <= S_FILL;
          end
        end
        default: state_q <= S_FILL;
      endcase
    end
  end

  assign m_axis_tvalid = ovalid_q;
  assign m_axis_tdata  = odata_q;
  assign m_axis_tkeep  = okeep_q;
  assign m_axis_tlast  = olast_q;
  assign m_axis_tuser  = ouser_q;
  assign crop_err      = crop_err_q;
  assign frame_done    = frame_done_q;

endmodule
